// File: rtl/obs_tap_pkg.sv
// Shared types and sizing helpers for the observation tap read-out path.
package obs_tap_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  // Width of a counter that must hold values 0..obs_w inclusive.
  function automatic int unsigned bit_cnt_w(int unsigned obs_w);
    return $clog2(obs_w + 1);
  endfunction

  // FIFO pointers carry one extra wrap bit beyond the address.
  function automatic int unsigned ptr_w(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned BIT_CNT_W = bit_cnt_w(16);

endpackage

// File: rtl/obs_frame_fifo.sv
// Frame FIFO for captured observation words; wrap-bit pointers tell full from empty.
module obs_frame_fifo
  import obs_tap_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PtrW  = ptr_w(DEPTH);
  localparam int unsigned AddrW = PtrW - 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  logic [W-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic            do_push, do_pop;

  assign full_o  = (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]) &&
                   (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = CntW'(wr_ptr_q - rd_ptr_q);
  assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/obs_tap_reader.sv
// Captures observation-bus frames into a FIFO and streams each out MSB first plus even parity.
module obs_tap_reader
  import obs_tap_pkg::*;
#(
  parameter int unsigned OBS_W       = 16,
  parameter int unsigned FRAME_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [OBS_W-1:0]                 obs_i,
  input  logic                             capture_i,
  input  logic                             clr_ovf_i,
  input  logic                             so_ready_i,
  output logic                             so_valid_o,
  output logic                             so_data_o,
  output logic                             so_last_o,
  output logic                             busy_o,
  output logic                             overflow_o,
  output logic [$clog2(FRAME_DEPTH+1)-1:0] frame_cnt_o
);

  localparam int unsigned CntW    = $clog2(FRAME_DEPTH + 1);
  localparam int unsigned BitCntW = bit_cnt_w(OBS_W);

  state_e             state_q, state_d;
  // Frame data with the parity bit appended below it; the MSB is always the bit on the wire.
  logic [OBS_W:0]     shift_q, shift_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [OBS_W-1:0]   fifo_rdata;
  logic [CntW-1:0]    fifo_count, cnt_next;
  logic               xfer;

  assign fifo_push = capture_i && !fifo_full;
  assign xfer      = (state_q == StShift) && so_ready_i;

  obs_frame_fifo #(
    .W     (OBS_W),
    .DEPTH (FRAME_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (obs_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    fifo_pop  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) fifo_pop = 1'b1;
      end
      StShift: begin
        if (xfer) begin
          if (bit_cnt_q != '0) begin
            shift_d   = shift_q << 1;
            bit_cnt_d = bit_cnt_q - BitCntW'(1);
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
          end else begin
            state_d = StIdle;
            shift_d = '0;
          end
        end
      end
    endcase

    if (fifo_pop) begin
      state_d   = StShift;
      shift_d   = {fifo_rdata, ^fifo_rdata};
      bit_cnt_d = BitCntW'(OBS_W);
    end

    last_d   = (state_d == StShift) && (bit_cnt_d == '0);
    cnt_next = fifo_count + CntW'(fifo_push) - CntW'(fifo_pop);
    busy_d   = (state_d == StShift) || (cnt_next != '0);

    // A drop in the same cycle as a clear leaves the flag set.
    if (capture_i && fifo_full) ovf_d = 1'b1;
    else if (clr_ovf_i)         ovf_d = 1'b0;
    else                        ovf_d = ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  assign so_valid_o  = (state_q == StShift);
  assign so_data_o   = shift_q[OBS_W];
  assign so_last_o   = last_q;
  assign busy_o      = busy_q;
  assign overflow_o  = ovf_q;
  assign frame_cnt_o = fifo_count;

endmodule

// File: tb/tb_obs_tap_reader.sv
// Randomised scoreboard bench for obs_tap_reader against a frame-level reference model.
module tb_obs_tap_reader;

  localparam int unsigned OBS_W = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [OBS_W-1:0] obs_i = '0;
  logic             capture_i = 1'b0;
  logic             clr_ovf_i = 1'b0;
  logic             so_ready_i = 1'b0;
  logic             so_valid_o, so_data_o, so_last_o, busy_o, overflow_o;
  logic [CntW-1:0]  frame_cnt_o;

  int tests = 0;
  int errors = 0;

  // Expected serial stream: {data, last} per bit, pushed at capture, popped at transfer.
  logic [1:0] exp_q[$];

  // Frame-level reference state.
  int m_wait  = 0;
  bit m_shift = 1'b0;
  int m_left  = 0;
  bit m_ovf   = 1'b0;

  obs_tap_reader #(
    .OBS_W       (OBS_W),
    .FRAME_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .obs_i       (obs_i),
    .capture_i   (capture_i),
    .clr_ovf_i   (clr_ovf_i),
    .so_ready_i  (so_ready_i),
    .so_valid_o  (so_valid_o),
    .so_data_o   (so_data_o),
    .so_last_o   (so_last_o),
    .busy_o      (busy_o),
    .overflow_o  (overflow_o),
    .frame_cnt_o (frame_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: compare status outputs, then advance over the coming rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_wait  = 0;
      m_shift = 1'b0;
      m_left  = 0;
      m_ovf   = 1'b0;
    end else begin
      bit full;
      check("valid", {31'b0, so_valid_o}, {31'b0, m_shift});
      check("frame_cnt", 32'(frame_cnt_o), 32'(m_wait));
      check("overflow", {31'b0, overflow_o}, {31'b0, m_ovf});
      check("busy", {31'b0, busy_o}, {31'b0, (m_shift || m_wait > 0)});

      full = (m_wait == DEPTH);
      if (!m_shift) begin
        if (m_wait > 0) begin
          m_wait--;
          m_shift = 1'b1;
          m_left  = OBS_W + 1;
        end
      end else if (so_ready_i) begin
        m_left--;
        if (m_left == 0) begin
          if (m_wait > 0) begin
            m_wait--;
            m_left = OBS_W + 1;
          end else begin
            m_shift = 1'b0;
          end
        end
      end

      if (capture_i && full) begin
        m_ovf = 1'b1;
      end else begin
        if (clr_ovf_i) m_ovf = 1'b0;
        if (capture_i) begin
          m_wait++;
          for (int i = OBS_W - 1; i >= 0; i--) exp_q.push_back({obs_i[i], 1'b0});
          exp_q.push_back({^obs_i, 1'b1});
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  bit   stall = 1'b0;
  logic hold_d, hold_l;
  int   xfers = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall = 1'b0;
    end else begin
      logic [1:0] e;
      if (stall) begin
        check("hold_valid", {31'b0, so_valid_o}, 32'd1);
        check("hold_data", {31'b0, so_data_o}, {31'b0, hold_d});
        check("hold_last", {31'b0, so_last_o}, {31'b0, hold_l});
      end
      if (so_valid_o && so_ready_i) begin
        xfers++;
        if (exp_q.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL unexpected_bit: got data %0b last %0b, expected no transfer",
                   so_data_o, so_last_o);
        end else begin
          e = exp_q.pop_front();
          check("bit_data", {31'b0, so_data_o}, {31'b0, e[1]});
          check("bit_last", {31'b0, so_last_o}, {31'b0, e[0]});
        end
      end
      stall  = so_valid_o && !so_ready_i;
      hold_d = so_data_o;
      hold_l = so_last_o;
    end
  end

  // Drive inputs for the next rising edge, then move just past it.
  task automatic step(input logic cap, input logic [OBS_W-1:0] d, input logic rdy,
                      input logic clr);
    capture_i  = cap;
    obs_i      = d;
    so_ready_i = rdy;
    clr_ovf_i  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((busy_o || so_valid_o || exp_q.size() != 0) && n < budget) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    check("drain_done", {31'b0, (n < budget)}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'b0, so_valid_o}, 32'd0);
    check({tag, "_data"}, {31'b0, so_data_o}, 32'd0);
    check({tag, "_last"}, {31'b0, so_last_o}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy_o}, 32'd0);
    check({tag, "_ovf"}, {31'b0, overflow_o}, 32'd0);
    check({tag, "_cnt"}, 32'(frame_cnt_o), 32'd0);
  endtask

  initial begin
    int run;
    int x0;

    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);

    // Single frame with continuous ready.
    step(1'b1, 16'hA5C3, 1'b1, 1'b0);
    drain(60);

    // Same frame under a 1,0,0,1 ready pattern.
    x0 = xfers;
    step(1'b1, 16'hA5C3, 1'b1, 1'b0);
    for (int i = 0; i < 80; i++) step(1'b0, '0, (i % 4 == 0) || (i % 4 == 3), 1'b0);
    drain(60);
    check("bp_transfers", 32'(xfers - x0), 32'd17);

    // Overflow: six captures while stalled, one is dropped.
    for (int i = 0; i < 6; i++) step(1'b1, 16'(16'h1111 * (i + 1)), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("ovf_cnt", 32'(frame_cnt_o), 32'd4);
    check("ovf_flag", {31'b0, overflow_o}, 32'd1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("ovf_clr", {31'b0, overflow_o}, 32'd0);
    x0 = xfers;
    drain(200);
    check("ovf_transfers", 32'(xfers - x0), 32'd85);

    // Back-to-back frames without a gap.
    step(1'b1, 16'h0001, 1'b1, 1'b0);
    step(1'b1, 16'hFFFF, 1'b1, 1'b0);
    capture_i = 1'b0;
    run = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (so_valid_o) run++;
      else if (run > 0) break;
    end
    check("b2b_run", 32'(run), 32'd34);
    @(posedge clk);
    #1;
    drain(60);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0);
    drain(400);

    // Reset mid-frame with frames still queued.
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    step(1'b1, 16'h5678, 1'b0, 1'b0);
    step(1'b1, 16'h9ABC, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("pre_reset_valid", {31'b0, so_valid_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    x0 = xfers;
    for (int i = 0; i < 30; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("no_residue", 32'(xfers - x0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
